// File: rtl/board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_pkg : shared cell encodings, directions and FSM state codes    |
// |             for the board_engine move checker / placer.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_A     = 2'b10;
    localparam logic [1:0] CELL_B     = 2'b11;

    typedef enum logic [2:0] {
        DIR_UP,
        DIR_UPRIGHT,
        DIR_RIGHT,
        DIR_DOWNRIGHT,
        DIR_DOWN,
        DIR_DOWNLEFT,
        DIR_LEFT,
        DIR_UPLEFT
    } dir_e;

    // Column/row deltas indexed by direction; "up" decreases the row.
    localparam logic signed [1:0] DIR_DX [8] = '{2'sb00, 2'sb01, 2'sb01, 2'sb01,
                                                 2'sb00, 2'sb11, 2'sb11, 2'sb11};
    localparam logic signed [1:0] DIR_DY [8] = '{2'sb11, 2'sb11, 2'sb00, 2'sb01,
                                                 2'sb01, 2'sb01, 2'sb00, 2'sb11};

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CHECK = 3'd1;
    localparam state_t ST_SCAN  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_engine_if : command, result, display and score signals of     |
// |                   board_engine.                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface board_engine_if #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
);
    localparam int FW = $clog2(N * N);
    localparam int SW = FW + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [1:0]    side;
    logic          done;
    logic          legal;
    logic [7:0]    dir;
    logic [FW-1:0] flip_count;
    logic [CW-1:0] rd_x;
    logic [CW-1:0] rd_y;
    logic [1:0]    rd_q;
    logic [SW-1:0] count_a;
    logic [SW-1:0] count_b;

    modport slave (
        input  cmd_valid, cmd_op, x, y, side, rd_x, rd_y,
        output cmd_ready, done, legal, dir, flip_count, rd_q, count_a, count_b
    );

    modport master (
        output cmd_valid, cmd_op, x, y, side, rd_x, rd_y,
        input  cmd_ready, done, legal, dir, flip_count, rd_q, count_a, count_b
    );

endinterface
`default_nettype wire

// File: rtl/board_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_stepper : combinational neighbour (x,y) + k*delta[d] with an  |
// |                 on-board flag.                                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module board_stepper
    import board_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    input  logic [2:0]    d_i,
    input  logic [CW-1:0] k_i,
    output logic [CW-1:0] nx_o,
    output logic [CW-1:0] ny_o,
    output logic          on_board_o
);

    localparam logic [CW+1:0] C_MAX = (CW+2)'(N - 1);

    // Two guard bits: a walk steps at most one cell past an edge, so the
    // sum never exceeds 2N-2 and a negative result always sets the top bit.
    function automatic logic [CW+1:0] offset(input logic [CW+1:0] base,
                                             input logic signed [1:0] delta,
                                             input logic [CW+1:0] k);
        if (delta == 2'sb01)      offset = base + k;
        else if (delta == 2'sb11) offset = base - k;
        else                      offset = base;
    endfunction

    logic [CW+1:0] w_k;
    logic [CW+1:0] w_sx;
    logic [CW+1:0] w_sy;

    assign w_k  = {2'b00, k_i};
    assign w_sx = offset({2'b00, x_i}, DIR_DX[d_i], w_k);
    assign w_sy = offset({2'b00, y_i}, DIR_DY[d_i], w_k);

    assign nx_o       = w_sx[CW-1:0];
    assign ny_o       = w_sy[CW-1:0];
    assign on_board_o = !w_sx[CW+1] && (w_sx <= C_MAX) &&
                        !w_sy[CW+1] && (w_sy <= C_MAX);

endmodule
`default_nettype wire

// File: rtl/board_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_engine : flanking-move detector and disc placer for an NxN    |
// |                board. Optional score counters: BOARD_ENGINE_SCORE_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module board_engine
    import board_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic           clock,
    input  logic           resetn,
    board_engine_if.slave  bus
);

    localparam int            FW     = $clog2(N * N);
    localparam int            SW     = FW + 1;
    localparam int            NA     = 1 << (2 * CW);
    localparam int            H      = N / 2;
    localparam logic [CW-1:0] C_KMAX = CW'(N - 1);

    // Storage is addressed by {y,x}; entries outside NxN stay empty forever.
    function automatic logic [1:0] cell_init(input int i);
        int cx;
        int cy;
        cx = i % (1 << CW);
        cy = i >> CW;
        if ((cx == H - 1 && cy == H - 1) || (cx == H && cy == H)) cell_init = CELL_A;
        else if ((cx == H && cy == H - 1) || (cx == H - 1 && cy == H)) cell_init = CELL_B;
        else cell_init = CELL_EMPTY;
    endfunction

    logic [1:0]    board_q [NA];
    state_t        state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, k_q, k_d;
    logic [1:0]    side_q, side_d;
    logic          op_q, op_d, legal_q, legal_d, wfirst_q, wfirst_d;
    logic [2:0]    didx_q, didx_d;
    logic [7:0]    scan_q, scan_d, dir_q, dir_d, wrem_q, wrem_d;
    logic [FW-1:0] flip_q, flip_d;

    logic [CW-1:0]   w_nx, w_ny;
    logic            w_on, w_end, w_pass, w_we;
    logic [1:0]      w_cell, w_tcell, w_opp;
    logic [7:0]      w_mask, w_rem;
    logic [2*CW-1:0] w_waddr;

    board_stepper #(.N(N), .CW(CW)) u_stepper (
        .x_i        (x_q),
        .y_i        (y_q),
        .d_i        (didx_q),
        .k_i        (k_q),
        .nx_o       (w_nx),
        .ny_o       (w_ny),
        .on_board_o (w_on)
    );

    assign w_cell  = board_q[{w_ny, w_nx}];
    assign w_tcell = board_q[{y_q, x_q}];
    assign w_opp   = {1'b1, ~side_q[0]};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        side_d   = side_q;
        op_d     = op_q;
        didx_d   = didx_q;
        k_d      = k_q;
        scan_d   = scan_q;
        dir_d    = dir_q;
        legal_d  = legal_q;
        flip_d   = flip_q;
        wfirst_d = wfirst_q;
        wrem_d   = wrem_q;
        w_we     = 1'b0;
        w_waddr  = {w_ny, w_nx};
        w_end    = 1'b0;
        w_pass   = 1'b0;
        w_mask   = scan_q;
        w_rem    = wrem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = ST_CHECK;
                    x_d     = bus.x;
                    y_d     = bus.y;
                    side_d  = bus.side;
                    op_d    = bus.cmd_op;
                    flip_d  = '0;
                end
            end
            ST_CHECK: begin
                if (w_tcell[1]) begin
                    dir_d   = '0;
                    legal_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                    didx_d  = 3'd0;
                    k_d     = CW'(1);
                    scan_d  = '0;
                end
            end
            ST_SCAN: begin
                if (!w_on || !w_cell[1]) begin
                    w_end = 1'b1;
                end else if (w_cell == side_q) begin
                    w_end  = 1'b1;
                    w_pass = (k_q != CW'(1));
                end else if (k_q == C_KMAX) begin
                    w_end = 1'b1;
                end
                w_mask = scan_q | (w_pass ? (8'd1 << didx_q) : 8'd0);
                if (w_end) begin
                    scan_d = w_mask;
                    k_d    = CW'(1);
                    didx_d = didx_q + 3'd1;
                    if (didx_q == 3'd7) begin
                        dir_d    = w_mask;
                        legal_d  = |w_mask;
                        wfirst_d = 1'b1;
                        wrem_d   = w_mask;
                        state_d  = (op_q && |w_mask) ? ST_WRITE : ST_DONE;
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_WRITE: begin
                // The scan guarantees each set direction ends on an own disc.
                if (wfirst_q) begin
                    w_we     = 1'b1;
                    w_waddr  = {y_q, x_q};
                    wfirst_d = 1'b0;
                    didx_d   = lowest_set(wrem_q);
                    k_d      = CW'(1);
                end else if (w_on && w_cell == w_opp) begin
                    w_we   = 1'b1;
                    flip_d = flip_q + FW'(1);
                    k_d    = k_q + CW'(1);
                end else begin
                    w_rem  = wrem_q & ~(8'd1 << didx_q);
                    wrem_d = w_rem;
                    didx_d = lowest_set(w_rem);
                    k_d    = CW'(1);
                    if (w_rem == 8'd0) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            side_q   <= CELL_A;
            op_q     <= 1'b0;
            didx_q   <= 3'd0;
            k_q      <= CW'(1);
            scan_q   <= '0;
            dir_q    <= '0;
            legal_q  <= 1'b0;
            flip_q   <= '0;
            wfirst_q <= 1'b0;
            wrem_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            side_q   <= side_d;
            op_q     <= op_d;
            didx_q   <= didx_d;
            k_q      <= k_d;
            scan_q   <= scan_d;
            dir_q    <= dir_d;
            legal_q  <= legal_d;
            flip_q   <= flip_d;
            wfirst_q <= wfirst_d;
            wrem_q   <= wrem_d;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            for (int i = 0; i < NA; i++) board_q[i] <= cell_init(i);
        end else if (w_we) begin
            board_q[w_waddr] <= side_q;
        end
    end

`ifdef BOARD_ENGINE_SCORE_EN
    logic [SW-1:0] cnt_a_q, cnt_b_q;

    // First write is the placed disc; later writes move a disc between sides.
    always_ff @(posedge clock) begin
        if (resetn) begin
            cnt_a_q <= SW'(2);
            cnt_b_q <= SW'(2);
        end else if (w_we) begin
            if (!side_q[0]) begin
                cnt_a_q <= cnt_a_q + SW'(1);
                if (!wfirst_q) cnt_b_q <= cnt_b_q - SW'(1);
            end else begin
                cnt_b_q <= cnt_b_q + SW'(1);
                if (!wfirst_q) cnt_a_q <= cnt_a_q - SW'(1);
            end
        end
    end

    assign bus.count_a = cnt_a_q;
    assign bus.count_b = cnt_b_q;
`else
    assign bus.count_a = '0;
    assign bus.count_b = '0;
`endif

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.legal      = legal_q;
    assign bus.dir        = dir_q;
    assign bus.flip_count = flip_q;
    assign bus.rd_q       = board_q[{bus.rd_y, bus.rd_x}];

endmodule
`default_nettype wire

// File: tb/tb_board_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_board_engine : directed + random commands against a cell-array   |
// |                   reference model of the board rules.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_board_engine;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam logic [1:0] SA = 2'b10;
    localparam logic [1:0] SB = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_engine_if #(.N(N)) bif();
    board_engine #(.N(N)) dut (
        .clock  (clk),
        .resetn (rst),
        .bus    (bif.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [1:0] bm [N][N];   // [row][col]
    int DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit on_b(int cx, int cy);
        return cx >= 0 && cx < N && cy >= 0 && cy < N;
    endfunction

    function automatic logic [7:0] m_dirs(int x, int y, logic [1:0] s);
        logic [7:0] m = 8'd0;
        if (bm[y][x][1]) return 8'd0;
        for (int d = 0; d < 8; d++) begin
            for (int k = 1; k < N; k++) begin
                int cx = x + DX[d] * k;
                int cy = y + DY[d] * k;
                if (!on_b(cx, cy)) break;
                if (!bm[cy][cx][1]) break;
                if (bm[cy][cx] == s) begin
                    if (k >= 2) m[d] = 1'b1;
                    break;
                end
            end
        end
        return m;
    endfunction

    function automatic int m_scan_cycles(int x, int y, logic [1:0] s);
        int cnt = 0;
        for (int d = 0; d < 8; d++) begin
            for (int k = 1; k < N; k++) begin
                int cx = x + DX[d] * k;
                int cy = y + DY[d] * k;
                cnt++;
                if (!on_b(cx, cy)) break;
                if (!bm[cy][cx][1] || bm[cy][cx] == s) break;
            end
        end
        return cnt;
    endfunction

    function automatic int m_count(logic [1:0] c);
        int n = 0;
        for (int yy = 0; yy < N; yy++)
            for (int xx = 0; xx < N; xx++)
                if (bm[yy][xx] == c) n++;
        return n;
    endfunction

    task automatic m_place(input int x, input int y, input logic [1:0] s,
                           input logic [7:0] m, output int flips);
        flips = 0;
        bm[y][x] = s;
        for (int d = 0; d < 8; d++) begin
            if (m[d]) begin
                for (int k = 1; bm[y + DY[d] * k][x + DX[d] * k] != s; k++) begin
                    bm[y + DY[d] * k][x + DX[d] * k] = s;
                    flips++;
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int yy = 0; yy < N; yy++)
            for (int xx = 0; xx < N; xx++)
                bm[yy][xx] = 2'b00;
        bm[N/2-1][N/2-1] = SA;
        bm[N/2][N/2]     = SA;
        bm[N/2-1][N/2]   = SB;
        bm[N/2][N/2-1]   = SB;
    endtask

    task automatic check_board(input string tag);
        for (int yy = 0; yy < N; yy++) begin
            for (int xx = 0; xx < N; xx++) begin
                bif.rd_x = CW'(xx);
                bif.rd_y = CW'(yy);
                #1;
                check_value($sformatf("%s cell(%0d,%0d)", tag, xx, yy), 32'(bif.rd_q), 32'(bm[yy][xx]));
            end
        end
    endtask

    task automatic check_counts(input string tag);
`ifdef BOARD_ENGINE_SCORE_EN
        check_value({tag, " count_a"}, 32'(bif.count_a), 32'(m_count(SA)));
        check_value({tag, " count_b"}, 32'(bif.count_b), 32'(m_count(SB)));
`else
        check_value({tag, " count_a"}, 32'(bif.count_a), 32'd0);
        check_value({tag, " count_b"}, 32'(bif.count_b), 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bif.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic run_cmd(input bit op, input int x, input int y, input logic [1:0] s,
                           input int busy_at, output int lat);
        logic [7:0] exp_dir;
        int exp_lat, exp_flip, dones;
        bit do_write;
        exp_dir  = m_dirs(x, y, s);
        exp_lat  = bm[y][x][1] ? 2 : m_scan_cycles(x, y, s) + 2;
        do_write = op && (exp_dir != 8'd0);
        @(negedge clk);
        check_value("ready idle", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.x         = CW'(x);
        bif.y         = CW'(y);
        bif.side      = s;
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 1'($urandom);
        bif.x         = CW'($urandom);
        bif.y         = CW'($urandom);
        bif.side      = {1'b1, 1'($urandom)};
        lat   = 0;
        dones = 0;
        while (dones == 0 && lat < 300) begin
            @(negedge clk);
            lat++;
            if (busy_at != 0 && lat == busy_at) begin
                check_value("ready busy", 32'(bif.cmd_ready), 32'd0);
                bif.cmd_valid = 1'b1;
                bif.cmd_op    = 1'b1;
            end else begin
                bif.cmd_valid = 1'b0;
            end
            if (bif.done) dones++;
        end
        bif.cmd_valid = 1'b0;
        check_value("done seen", 32'(dones), 32'd1);
        if (!do_write) check_value("latency", 32'(lat), 32'(exp_lat));
        if (do_write) m_place(x, y, s, exp_dir, exp_flip);
        else exp_flip = 0;
        check_value("legal", 32'(bif.legal), 32'(exp_dir != 8'd0));
        check_value("dir", 32'(bif.dir), 32'(exp_dir));
        check_value("flip_count", 32'(bif.flip_count), 32'(exp_flip));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        check_value("done count", 32'(dones), 32'd1);
        check_value("ready after", 32'(bif.cmd_ready), 32'd1);
        check_counts("cmd");
        check_board("cmd");
    endtask

    initial begin
        int lat, dones, scan;
        logic [1:0] q;
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = 1'b0;
        bif.x         = '0;
        bif.y         = '0;
        bif.side      = SA;
        bif.rd_x      = '0;
        bif.rd_y      = '0;

        do_reset();
        check_value("rst ready", 32'(bif.cmd_ready), 32'd1);
        check_value("rst done", 32'(bif.done), 32'd0);
        check_value("rst legal", 32'(bif.legal), 32'd0);
        check_value("rst dir", 32'(bif.dir), 32'd0);
        check_value("rst flip", 32'(bif.flip_count), 32'd0);
        check_counts("rst");
        check_board("rst");

        run_cmd(1'b0, 5, 3, SA, 0, lat);
        check_value("detect53 dir", 32'(bif.dir), 32'h40);
        run_cmd(1'b1, 5, 3, SA, 0, lat);
        check_value("place53 flips", 32'(bif.flip_count), 32'd1);

        do_reset();
        run_cmd(1'b0, 0, 0, SA, 0, lat);
        check_value("corner latency", 32'(lat), 32'd10);
        run_cmd(1'b1, 3, 3, SB, 0, lat);
        check_value("occupied latency", 32'(lat), 32'd2);
        run_cmd(1'b0, 5, 3, SA, 4, lat);

        // Abort a place in its second WRITE cycle (target already written).
        do_reset();
        scan = m_scan_cycles(5, 3, SA);
        @(negedge clk);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = 1'b1;
        bif.x         = CW'(5);
        bif.y         = CW'(3);
        bif.side      = SA;
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < scan + 3; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        bif.rd_x = CW'(5);
        bif.rd_y = CW'(3);
        #1;
        q = bif.rd_q;
        check_value("write started", 32'(q), 32'(SA));
        rst = 1'b1;
        @(negedge clk);
        if (bif.done) dones++;
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        check_value("abort no done", 32'(dones), 32'd0);
        check_value("abort ready", 32'(bif.cmd_ready), 32'd1);
        check_value("abort legal", 32'(bif.legal), 32'd0);
        check_value("abort dir", 32'(bif.dir), 32'd0);
        check_value("abort flip", 32'(bif.flip_count), 32'd0);
        check_counts("abort");
        check_board("abort");

        do_reset();
        for (int n = 0; n < 40; n++) begin
            int cand_x [$];
            int cand_y [$];
            int px, py, pick;
            logic [1:0] s;
            s = ($urandom_range(0, 1) == 1) ? SB : SA;
            for (int yy = 0; yy < N; yy++)
                for (int xx = 0; xx < N; xx++)
                    if (m_dirs(xx, yy, s) != 8'd0) begin
                        cand_x.push_back(xx);
                        cand_y.push_back(yy);
                    end
            if (cand_x.size() > 0 && $urandom_range(0, 9) < 7) begin
                pick = $urandom_range(0, cand_x.size() - 1);
                px = cand_x[pick];
                py = cand_y[pick];
            end else begin
                px = $urandom_range(0, N - 1);
                py = $urandom_range(0, N - 1);
            end
            run_cmd(($urandom_range(0, 3) != 0), px, py, s, 0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
